// File: rtl/cache_pkg.sv
// Shared sizing, address slicing helpers and flush FSM encoding for the
// direct-mapped cache store.
package cache_pkg;

   localparam int LINES   = 16;
   localparam int INDEX_W = $clog2(LINES);
   localparam int TAG_W   = 32 - 2 - INDEX_W;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } cache_state_e;

   function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
      return addr[2 +: INDEX_W];
   endfunction

   function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
      return addr[31 -: TAG_W];
   endfunction

endpackage

// File: rtl/cache_stat_ctr.sv
// 32-bit saturating event counter with synchronous clear; clear beats increment.
module cache_stat_ctr (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        inc_i,
   input  logic        clr_i,
   output logic [31:0] cnt_o
);

   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_store.sv
// Direct-mapped tag/valid/data store with combinational lookup and a one-line-per-cycle
// flush sweep. Define CACHE_STATS_EN to add saturating hit/miss lookup counters.
module cache_store
   import cache_pkg::*;
(
   input  logic         CLK,
   input  logic         RST,
   input  logic [31:0]  ADDR,
   input  logic [31:0]  CDIN,
   input  logic         CWE,
   input  logic         LOOKUP,
   input  logic         FLUSH,
   output logic         FOUND,
   output logic [31:0]  CDOUT,
   output logic         BUSY,
   output logic [31:0]  HIT_CNT,
   output logic [31:0]  MISS_CNT,
   output cache_state_e DBG_STATE
);

   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   tag;
   cache_state_e       state_q, state_d;
   logic [INDEX_W-1:0] cnt_q, cnt_d;
   logic [LINES-1:0]   valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [31:0]        data_q [LINES];
   logic               wr_en;
   logic               sweep_start;
   logic               addr_unused;

   assign idx         = addr_index(ADDR);
   assign tag         = addr_tag(ADDR);
   assign addr_unused = ^ADDR[1:0];

   // A flush in IDLE takes priority over a simultaneous write; SWEEP ignores both.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      valid_d     = valid_q;
      wr_en       = 1'b0;
      sweep_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (FLUSH) begin
               state_d     = SWEEP;
               cnt_d       = '0;
               sweep_start = 1'b1;
            end else if (CWE) begin
               wr_en        = 1'b1;
               valid_d[idx] = 1'b1;
            end
         end
         SWEEP: begin
            valid_d[cnt_q] = 1'b0;
            if (cnt_q == INDEX_W'(LINES - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   // Tag and data arrays carry no reset; valid_q alone qualifies them.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         data_q[idx] <= CDIN;
         tag_q[idx]  <= tag;
      end
   end

   assign BUSY      = (state_q == SWEEP);
   assign FOUND     = valid_q[idx] && (tag_q[idx] == tag) && !BUSY;
   assign CDOUT     = data_q[idx];
   assign DBG_STATE = state_q;

`ifdef CACHE_STATS_EN
   logic hit_inc, miss_inc;

   assign hit_inc  = LOOKUP && !BUSY && FOUND;
   assign miss_inc = LOOKUP && !BUSY && !FOUND;

   cache_stat_ctr u_hit_ctr (
      .clk_i  (CLK),
      .rst_ni (RST),
      .inc_i  (hit_inc),
      .clr_i  (sweep_start),
      .cnt_o  (HIT_CNT)
   );

   cache_stat_ctr u_miss_ctr (
      .clk_i  (CLK),
      .rst_ni (RST),
      .inc_i  (miss_inc),
      .clr_i  (sweep_start),
      .cnt_o  (MISS_CNT)
   );
`else
   logic stats_unused;

   assign stats_unused = ^{LOOKUP, sweep_start};
   assign HIT_CNT      = '0;
   assign MISS_CNT     = '0;
`endif

endmodule

// File: tb/tb_cache_store.sv
// Directed bench for cache_store: vector table for fills/lookups plus hand-written
// flush, drop and reset-during-sweep sequences.
module tb_cache_store;
   import cache_pkg::*;

   logic         CLK;
   logic         RST;
   logic [31:0]  ADDR;
   logic [31:0]  CDIN;
   logic         CWE;
   logic         LOOKUP;
   logic         FLUSH;
   logic         FOUND;
   logic [31:0]  CDOUT;
   logic         BUSY;
   logic [31:0]  HIT_CNT;
   logic [31:0]  MISS_CNT;
   cache_state_e DBG_STATE;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] FILL_BASE = 32'h0000_1000;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] din;
      logic        we;
      logic        exp_found;
      logic        chk_dout;
      logic [31:0] exp_dout;
   } vec_t;

   vec_t vecs[13];

   cache_store dut (
      .CLK       (CLK),
      .RST       (RST),
      .ADDR      (ADDR),
      .CDIN      (CDIN),
      .CWE       (CWE),
      .LOOKUP    (LOOKUP),
      .FLUSH     (FLUSH),
      .FOUND     (FOUND),
      .CDOUT     (CDOUT),
      .BUSY      (BUSY),
      .HIT_CNT   (HIT_CNT),
      .MISS_CNT  (MISS_CNT),
      .DBG_STATE (DBG_STATE)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic write_line(input logic [31:0] a, input logic [31:0] d);
      ADDR = a;
      CDIN = d;
      CWE  = 1'b1;
      tick();
      CWE  = 1'b0;
   endtask

   task automatic expect_line(input string name, input logic [31:0] a,
                              input logic f, input logic [31:0] d);
      ADDR = a;
      #1;
      check({name, "_found"}, 32'(FOUND), 32'(f));
      if (f) check({name, "_dout"}, CDOUT, d);
   endtask

   task automatic do_lookup(input logic [31:0] a);
      ADDR   = a;
      LOOKUP = 1'b1;
      tick();
      LOOKUP = 1'b0;
   endtask

   // Starts a flush (optionally with a same-cycle write), then counts BUSY cycles
   // while checking FOUND stays low; optional write/flush injected mid-sweep.
   task automatic run_flush(input logic start_we, input logic [31:0] start_addr,
                            input int we_at, input logic [31:0] we_addr,
                            input int fl_at, output int n);
      n     = 0;
      FLUSH = 1'b1;
      CWE   = start_we;
      ADDR  = start_addr;
      CDIN  = 32'hC0DE_0000;
      tick();
      FLUSH = 1'b0;
      CWE   = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (!BUSY) break;
         n++;
         CWE   = (k == we_at);
         FLUSH = (k == fl_at);
         ADDR  = (k == we_at) ? we_addr : FILL_BASE + 32'(k * 4);
         CDIN  = 32'hBAD0_0000 + 32'(k);
         #1;
         check($sformatf("sweep_found_low_%0d", k), 32'(FOUND), 32'd0);
         tick();
      end
      CWE   = 1'b0;
      FLUSH = 1'b0;
   endtask

   initial begin
      int n;

      vecs[0]  = '{32'h0000_0040, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
      vecs[1]  = '{32'h0000_0040, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[2]  = '{32'h0000_0040, 32'h0,         1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF};
      vecs[3]  = '{32'h0000_0080, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[4]  = '{32'h0000_0040, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
      vecs[5]  = '{32'h0000_0080, 32'h0,         1'b0, 1'b1, 1'b1, 32'h1234_5678};
      vecs[6]  = '{32'h0000_0044, 32'h0000_0044, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[7]  = '{32'h0000_0044, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0044};
      vecs[8]  = '{32'h0000_0043, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
      vecs[9]  = '{32'h0000_0083, 32'h0,         1'b0, 1'b1, 1'b1, 32'h1234_5678};
      vecs[10] = '{32'hFFFF_FFFC, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[11] = '{32'hFFFF_FFFC, 32'h0,         1'b0, 1'b1, 1'b1, 32'hA5A5_A5A5};
      vecs[12] = '{32'h0000_003C, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0};

      RST    = 1'b0;
      ADDR   = 32'h0000_0040;
      CDIN   = '0;
      CWE    = 1'b0;
      LOOKUP = 1'b0;
      FLUSH  = 1'b0;
      #2;
      check("rst_found", 32'(FOUND), 32'd0);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_state", 32'(DBG_STATE), 32'(IDLE));
      check("rst_hit_cnt", HIT_CNT, 32'd0);
      check("rst_miss_cnt", MISS_CNT, 32'd0);
      tick();
      tick();
      RST = 1'b1;

      // fill / conflict / ignored-offset vectors
      for (int i = 0; i < 13; i++) begin
         ADDR = vecs[i].addr;
         CDIN = vecs[i].din;
         CWE  = vecs[i].we;
         #1;
         check($sformatf("vec%0d_found", i), 32'(FOUND), 32'(vecs[i].exp_found));
         if (vecs[i].chk_dout) check($sformatf("vec%0d_dout", i), CDOUT, vecs[i].exp_dout);
         tick();
      end
      CWE = 1'b0;

      // full fill then flush with a dropped mid-sweep write and an ignored FLUSH
      for (int i = 0; i < LINES; i++) write_line(FILL_BASE + 32'(i * 4), 32'h5000_0000 + 32'(i));
      for (int i = 0; i < LINES; i++)
         expect_line($sformatf("fill%0d", i), FILL_BASE + 32'(i * 4), 1'b1, 32'h5000_0000 + 32'(i));
      run_flush(1'b0, 32'h0, 5, 32'h0000_2000, 8, n);
      check("flush_len", 32'(n), 32'd16);
      check("flush_idle", 32'(DBG_STATE), 32'(IDLE));
      for (int i = 0; i < LINES; i++)
         expect_line($sformatf("post_flush%0d", i), FILL_BASE + 32'(i * 4), 1'b0, 32'h0);
      expect_line("busy_write_dropped", 32'h0000_2000, 1'b0, 32'h0);

      // FLUSH and CWE together: the write loses
      run_flush(1'b1, 32'h0000_3004, -1, 32'h0, -1, n);
      check("flush2_len", 32'(n), 32'd16);
      expect_line("flush_cwe_dropped", 32'h0000_3004, 1'b0, 32'h0);

      // reset in the middle of a sweep
      write_line(32'h0000_0040, 32'h1111_2222);
      write_line(32'h0000_0068, 32'h3333_4444);
      expect_line("pre_rst_hit", 32'h0000_0068, 1'b1, 32'h3333_4444);
      FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0;
      repeat (5) tick();
      check("mid_sweep_busy", 32'(BUSY), 32'd1);
      RST = 1'b0;
      #1;
      check("async_rst_busy", 32'(BUSY), 32'd0);
      check("async_rst_state", 32'(DBG_STATE), 32'(IDLE));
      tick();
      RST = 1'b1;
      expect_line("rst_sweep_miss40", 32'h0000_0040, 1'b0, 32'h0);
      expect_line("rst_sweep_miss68", 32'h0000_0068, 1'b0, 32'h0);
      write_line(32'h0000_0068, 32'h7777_8888);
      expect_line("post_rst_write", 32'h0000_0068, 1'b1, 32'h7777_8888);
      run_flush(1'b0, 32'h0, -1, 32'h0, -1, n);
      check("flush3_len", 32'(n), 32'd16);

      // lookup statistics
      write_line(32'h0000_0040, 32'hCAFE_0001);
      do_lookup(32'h0000_0040);
      do_lookup(32'h0000_0040);
      do_lookup(32'h0000_0040);
      do_lookup(32'h0000_0080);
      do_lookup(32'h0000_0084);
`ifdef CACHE_STATS_EN
      check("stat_hits", HIT_CNT, 32'd3);
      check("stat_misses", MISS_CNT, 32'd2);
      FLUSH  = 1'b1;
      tick();
      FLUSH  = 1'b0;
      check("stat_hits_clr", HIT_CNT, 32'd0);
      check("stat_misses_clr", MISS_CNT, 32'd0);
      do_lookup(32'h0000_0040);
      repeat (20) tick();
      check("stat_busy_hits", HIT_CNT, 32'd0);
      check("stat_busy_misses", MISS_CNT, 32'd0);
      write_line(32'h0000_0040, 32'hCAFE_0002);
      force dut.u_hit_ctr.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.u_hit_ctr.cnt_q;
      do_lookup(32'h0000_0040);
      check("stat_hit_saturate", HIT_CNT, 32'hFFFF_FFFF);
`else
      check("stat_hits_tied", HIT_CNT, 32'd0);
      check("stat_misses_tied", MISS_CNT, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
